// File: rtl/pixie_dma_arbiter_pkg.sv
// pixie_dma_arbiter_pkg: shared constants for the display DMA arbiter and the pixie
package pixie_dma_arbiter_pkg;
   localparam int ADDR_W_DEF   = 12;
   localparam int PEND_MAX_DEF = 2;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DMA_RD  = 3'd1;
   localparam logic [2:0] ST_DMA_CAP = 3'd2;
   localparam logic [2:0] ST_CPU_RD  = 3'd3;
   localparam logic [2:0] ST_CPU_CAP = 3'd4;
   localparam logic [2:0] ST_CPU_WR  = 3'd5;
   typedef enum logic [1:0] {SC_FETCH = 2'b00, SC_EXEC = 2'b01, SC_DMA = 2'b10, SC_INT = 2'b11} sc_t;
   function automatic int pend_w(input int pmax);
      return $clog2(pmax + 1);
   endfunction
endpackage

// File: rtl/pixie_dma_arbiter_if.sv
// pixie_dma_arbiter_if: CPU, RAM and display-fetch signals of the arbiter
interface pixie_dma_arbiter_if import pixie_dma_arbiter_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
   logic              dma_req;
   logic              frame_start;
   logic [ADDR_W-1:0] base_addr;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic              cpu_ack;
   logic [7:0]        cpu_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic [7:0]        dma_data;
   logic              dma_valid;
   logic              overrun;
   modport slave (
      input  dma_req, frame_start, base_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, dma_data, dma_valid, overrun
   );
   modport master (
      output dma_req, frame_start, base_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata, dma_data, dma_valid, overrun
   );
endinterface

// File: rtl/pixie_dma_arbiter_dma_ptr_counter.sv
// dma_ptr_counter: display refresh pointer, pending-fetch counter and sticky overrun flag
module dma_ptr_counter import pixie_dma_arbiter_pkg::*; #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int PEND_MAX = PEND_MAX_DEF
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_dma_req,
   input  logic              i_frame_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic              i_issue,
   output logic [ADDR_W-1:0] o_ptr,
   output logic              o_pend_nz,
   output logic              o_overrun
);
   localparam int PW = pend_w(PEND_MAX);
   logic [ADDR_W-1:0] r_ptr;
   logic [PW-1:0]     r_pend;
   logic              r_overrun;
   logic              w_drop;
   logic              w_inc;
   // a full counter only loses a request when no fetch frees a slot that cycle
   assign w_drop    = i_dma_req && (r_pend == PW'(PEND_MAX)) && !i_issue;
   assign w_inc     = i_dma_req && !w_drop;
   assign o_ptr     = r_ptr;
   assign o_pend_nz = r_pend != '0;
   assign o_overrun = r_overrun;
   // reload beats increment; issue already latched the old pointer into mem_addr
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_ptr     <= '0;
         r_pend    <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_ptr     <= i_frame_start ? i_base_addr : i_issue ? r_ptr + ADDR_W'(1) : r_ptr;
         r_pend    <= r_pend + PW'(w_inc) - PW'(i_issue);
         r_overrun <= r_overrun | w_drop;
      end
   end
endmodule

// File: rtl/pixie_dma_arbiter.sv
// pixie_dma_arbiter: shares one RAM port between CPU accesses and display DMA fetches
module pixie_dma_arbiter import pixie_dma_arbiter_pkg::*; #(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int PEND_MAX = PEND_MAX_DEF
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   pixie_dma_arbiter_if.slave io_bus
);
   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [7:0]        r_mem_wdata;
   logic [7:0]        r_dma_data;
   logic              r_dma_valid;
   logic [7:0]        r_cpu_rdata;
   logic              r_cpu_ack;
   logic [2:0]        w_next;
   logic [ADDR_W-1:0] w_ptr;
   logic              w_pend_nz;
   logic              w_overrun;
   logic              w_issue;
   logic              w_cpu_go;
   logic              w_cpu_wr;
   dma_ptr_counter #(.ADDR_W(ADDR_W), .PEND_MAX(PEND_MAX)) u_ptr (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_dma_req     (io_bus.dma_req),
      .i_frame_start (io_bus.frame_start),
      .i_base_addr   (io_bus.base_addr),
      .i_issue       (w_issue),
      .o_ptr         (w_ptr),
      .o_pend_nz     (w_pend_nz),
      .o_overrun     (w_overrun)
   );
   // display fetches win every IDLE arbitration; nothing preempts a running access
   assign w_issue  = (r_state == ST_IDLE) && w_pend_nz;
   assign w_cpu_go = (r_state == ST_IDLE) && !w_pend_nz && io_bus.cpu_req;
   assign w_cpu_wr = w_cpu_go && io_bus.cpu_we;
   // next-state selection
   always_comb begin
      w_next = (r_state == ST_IDLE)   ? (w_issue ? ST_DMA_RD : w_cpu_go ? (io_bus.cpu_we ? ST_CPU_WR : ST_CPU_RD) : ST_IDLE) :
               (r_state == ST_DMA_RD) ? ST_DMA_CAP :
               (r_state == ST_CPU_RD) ? ST_CPU_CAP : ST_IDLE;
   end
   // state register; reset abandons any access in flight
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end
   // RAM port drive and capture of read data one cycle after the address phase
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_dma_data  <= '0;
         r_dma_valid <= 1'b0;
         r_cpu_rdata <= '0;
         r_cpu_ack   <= 1'b0;
      end else begin
         r_mem_addr  <= w_issue ? w_ptr : w_cpu_go ? io_bus.cpu_addr : r_mem_addr;
         r_mem_we    <= w_cpu_wr;
         r_mem_wdata <= w_cpu_wr ? io_bus.cpu_wdata : r_mem_wdata;
         r_dma_data  <= (r_state == ST_DMA_CAP) ? io_bus.mem_rdata : r_dma_data;
         r_dma_valid <= r_state == ST_DMA_CAP;
         r_cpu_rdata <= (r_state == ST_CPU_CAP) ? io_bus.mem_rdata : r_cpu_rdata;
         r_cpu_ack   <= (r_state == ST_CPU_CAP) || (r_state == ST_CPU_WR);
      end
   end
   assign io_bus.mem_addr  = r_mem_addr;
   assign io_bus.mem_we    = r_mem_we;
   assign io_bus.mem_wdata = r_mem_wdata;
   assign io_bus.dma_data  = r_dma_data;
   assign io_bus.dma_valid = r_dma_valid;
   assign io_bus.cpu_rdata = r_cpu_rdata;
   assign io_bus.cpu_ack   = r_cpu_ack;
   assign io_bus.overrun   = w_overrun;
endmodule

// File: tb/tb_pixie_dma_arbiter.sv
// tb_pixie_dma_arbiter: directed checks of fetch latency, CPU access, priority, overrun, wrap and reset
module tb_pixie_dma_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_both = 0;
   logic [7:0] ram [0:4095];
   pixie_dma_arbiter_if #(.ADDR_W(12)) bus ();
   pixie_dma_arbiter #(.ADDR_W(12), .PEND_MAX(2)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .io_bus    (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction
   // synchronous RAM model, one-cycle read latency
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end
   // ack and valid must never coincide
   always @(posedge clk) if (bus.cpu_ack && bus.dma_valid) n_both <= n_both + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic fetch(input logic [11:0] ea, input logic fs, input logic [11:0] nb);
      bus.dma_req = 1'b1;
      tick();
      bus.dma_req = 1'b0;
      bus.frame_start = fs;
      bus.base_addr = nb;
      tick();
      bus.frame_start = 1'b0;
      chk("fetch_addr", 32'(bus.mem_addr), 32'(ea));
      tick();
      chk("fetch_early", 32'(bus.dma_valid), 0);
      tick();
      chk("fetch_valid", 32'(bus.dma_valid), 1);
      chk("fetch_data", 32'(bus.dma_data), 32'(pat(ea)));
      repeat (4) tick();
   endtask
   initial begin
      logic [7:0] d [0:3];
      int nv;
      int nbad;
      for (int i = 0; i < 4096; i++) ram[i] = pat(12'(i));
      bus.dma_req = 0; bus.frame_start = 0; bus.base_addr = 0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
      repeat (2) tick();
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_valid_ack_we", {bus.dma_valid, bus.cpu_ack, bus.mem_we, bus.overrun}, 0);
      chk("rst_data", {bus.dma_data, bus.cpu_rdata, bus.mem_wdata}, 0);
      rst_n = 1'b1;
      tick();
      bus.frame_start = 1; bus.base_addr = 12'h100;
      tick();
      bus.frame_start = 0;
      tick();
      for (int k = 0; k < 8; k++) fetch(12'h100 + 12'(k), 1'b0, 12'h000);
      bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 12'h200; bus.cpu_wdata = 8'h5A;
      tick();
      chk("wr_strobe", {bus.mem_we, bus.mem_wdata}, 9'h15A);
      chk("wr_addr", 32'(bus.mem_addr), 32'h200);
      chk("wr_noack", 32'(bus.cpu_ack), 0);
      tick();
      chk("wr_ack", 32'(bus.cpu_ack), 1);
      chk("wr_ram", 32'(ram[12'h200]), 32'h5A);
      bus.cpu_req = 0;
      tick();
      bus.cpu_req = 1; bus.cpu_we = 0;
      tick();
      tick();
      chk("rd_noack", 32'(bus.cpu_ack), 0);
      tick();
      chk("rd_ack", 32'(bus.cpu_ack), 1);
      chk("rd_data", 32'(bus.cpu_rdata), 32'h5A);
      bus.cpu_req = 0;
      repeat (2) tick();
      bus.dma_req = 1;
      tick();
      bus.dma_req = 0; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h200;
      tick();
      chk("pri_dma_addr", 32'(bus.mem_addr), 32'h108);
      repeat (2) tick();
      chk("pri_valid", 32'(bus.dma_valid), 1);
      chk("pri_cpu_wait", 32'(bus.cpu_ack), 0);
      repeat (2) tick();
      chk("pri_ack_early", 32'(bus.cpu_ack), 0);
      tick();
      chk("pri_ack", 32'(bus.cpu_ack), 1);
      chk("pri_rdata", 32'(bus.cpu_rdata), 32'h5A);
      bus.cpu_req = 0;
      repeat (3) tick();
      bus.dma_req = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 12'h300;
      repeat (3) tick();
      bus.dma_req = 0;
      chk("ovr_ack", 32'(bus.cpu_ack), 1);
      chk("ovr_rdata", 32'(bus.cpu_rdata), 32'(pat(12'h300)));
      chk("ovr_set", 32'(bus.overrun), 1);
      bus.cpu_req = 0;
      nv = 0;
      repeat (16) begin
         tick();
         if (bus.dma_valid) begin
            if (nv < 4) d[nv] = bus.dma_data;
            nv++;
         end
      end
      chk("ovr_count", 32'(nv), 2);
      chk("ovr_d0", 32'(d[0]), 32'(pat(12'h109)));
      chk("ovr_d1", 32'(d[1]), 32'(pat(12'h10A)));
      chk("ovr_sticky", 32'(bus.overrun), 1);
      bus.frame_start = 1; bus.base_addr = 12'hFFF;
      tick();
      bus.frame_start = 0;
      tick();
      fetch(12'hFFF, 1'b0, 12'h000);
      fetch(12'h000, 1'b0, 12'h000);
      fetch(12'h001, 1'b1, 12'h040);
      fetch(12'h040, 1'b0, 12'h000);
      chk("ovr_hold", 32'(bus.overrun), 1);
      bus.dma_req = 1;
      tick();
      bus.dma_req = 0;
      tick();
      chk("abort_addr", 32'(bus.mem_addr), 32'h041);
      rst_n = 0;
      tick();
      rst_n = 1;
      chk("abort_mem", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, 0);
      chk("abort_data", {bus.dma_data, bus.cpu_rdata}, 0);
      chk("abort_flags", {bus.dma_valid, bus.cpu_ack, bus.overrun}, 0);
      nbad = 0;
      repeat (8) begin
         tick();
         if (bus.dma_valid || bus.mem_addr != 0) nbad++;
      end
      chk("abort_quiet", 32'(nbad), 0);
      fetch(12'h000, 1'b0, 12'h000);
      chk("no_overlap", 32'(n_both), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
